// File: rtl/wrf_pkg.sv
// wrf_pkg: shared definitions for the WR fabric transmit path.
//   WRF_DW      - fabric data width (16-bit beats)
//   BCNT_W      - width of the per-frame beat counter
//   wrf_state_e - arbiter state encoding (IDLE/STREAM/DISCARD)
//   wrf_beat_t  - one buffered fabric beat {last, data}
package wrf_pkg;

    localparam int WRF_DW = 16;
    localparam int BCNT_W = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        DISCARD = 2'd2
    } wrf_state_e;

    typedef struct packed {
        logic              last;
        logic [WRF_DW-1:0] data;
    } wrf_beat_t;

endpackage

// File: rtl/wrf_skid_buf.sv
// wrf_skid_buf: 2-entry registered ready/valid buffer for WR fabric paths.
//   wrf_clk, wrf_rst       - clock, asynchronous active-high reset
//   in_valid/in_ready      - upstream handshake; in_ready = not full (registered)
//   in_data                - upstream beat
//   out_valid/out_ready    - downstream handshake; out_valid = not empty
//   out_data               - head entry, driven straight from a register
module wrf_skid_buf
    import wrf_pkg::*;
#(
    parameter int W = WRF_DW + 1
) (
    input  logic         wrf_clk,
    input  logic         wrf_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] head_q, tail_q;
    logic [1:0]   cnt_q;
    logic         push, pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge wrf_clk or posedge wrf_rst) begin
        if (wrf_rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= in_data;
                    else               tail_q <= in_data;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Count stays put; push cannot happen when full.
                    if (cnt_q == 2'd1) begin
                        head_q <= in_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wrf_tx_arbiter.sv
// wrf_tx_arbiter: whole-frame round-robin arbiter sharing one WR fabric
// transmit port between N_SRC frame sources, with max-length truncation
// and a 2-entry skid buffer on the output.
//   wrf_clk, wrf_rst                 - clock, asynchronous active-high reset
//   src_valid/src_last/src_data      - per-source beats (16 bits per source)
//   src_ready                        - per-source accept (only the owner)
//   wrf_valid/wrf_last/wrf_data      - fabric output beat
//   wrf_ready                        - fabric accept
//   grant                            - one-hot owner, zero when idle
//   busy                             - frame in progress
//   frame_trunc                      - one-cycle pulse after a frame is cut
// Build option: define WRF_ARB_PRIO_EN to give source 0 strict priority;
// the remaining sources then round-robin among themselves.
module wrf_tx_arbiter
    import wrf_pkg::*;
#(
    parameter int N_SRC     = 3,
    parameter int MAX_BEATS = 128
) (
    input  logic                    wrf_clk,
    input  logic                    wrf_rst,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC-1:0]        src_last,
    input  logic [WRF_DW*N_SRC-1:0] src_data,
    output logic [N_SRC-1:0]        src_ready,
    output logic                    wrf_valid,
    output logic                    wrf_last,
    output logic [WRF_DW-1:0]       wrf_data,
    input  logic                    wrf_ready,
    output logic [N_SRC-1:0]        grant,
    output logic                    busy,
    output logic                    frame_trunc
);

    if (N_SRC < 2 || N_SRC > 8) begin : g_bad_n_src
        $error("wrf_tx_arbiter: N_SRC must be in 2..8");
    end
    if (MAX_BEATS < 2 || MAX_BEATS > 1024) begin : g_bad_max_beats
        $error("wrf_tx_arbiter: MAX_BEATS must be in 2..1024");
    end

    localparam int IW = $clog2(N_SRC);

    // Lowest index the round-robin pointer may hold.
`ifdef WRF_ARB_PRIO_EN
    localparam logic [IW-1:0] RR_BASE = IW'(1);
`else
    localparam logic [IW-1:0] RR_BASE = IW'(0);
`endif

    wrf_state_e          state_q, state_d;
    logic [N_SRC-1:0]    grant_q, grant_d;
    logic [IW-1:0]       gidx_q, gidx_d;
    logic [IW-1:0]       rr_q, rr_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                trunc_q, trunc_d;

    logic [WRF_DW-1:0]   src_word [N_SRC];
    logic                g_valid, g_last, at_max;
    logic                push, push_last, skid_ready;
    logic                sel_any;
    logic [IW-1:0]       sel_idx;
    wrf_beat_t           skid_in, skid_out;

    for (genvar i = 0; i < N_SRC; i++) begin : g_word
        assign src_word[i] = src_data[i*WRF_DW +: WRF_DW];
    end

    assign g_valid = src_valid[gidx_q];
    assign g_last  = src_last[gidx_q];
    assign at_max  = (bcnt_q == BCNT_W'(MAX_BEATS - 1));

    function automatic logic [IW-1:0] next_rr(input logic [IW-1:0] g);
        logic [IW-1:0] n;
        if (int'(g) == N_SRC - 1) n = RR_BASE;
        else                      n = g + 1'b1;
        return n;
    endfunction

    // First requester at or after rr_q, with wrap.
    always_comb begin : arb
        int c;
        c       = 0;
        sel_any = 1'b0;
        sel_idx = '0;
`ifdef WRF_ARB_PRIO_EN
        if (src_valid[0]) begin
            sel_any = 1'b1;
        end else begin
            for (int k = 0; k < N_SRC - 1; k++) begin
                c = int'(rr_q) + k;
                if (c >= N_SRC) c = c - (N_SRC - 1);  // wrap into 1..N_SRC-1
                if (!sel_any && src_valid[c]) begin
                    sel_any = 1'b1;
                    sel_idx = c[IW-1:0];
                end
            end
        end
`else
        for (int k = 0; k < N_SRC; k++) begin
            c = int'(rr_q) + k;
            if (c >= N_SRC) c = c - N_SRC;
            if (!sel_any && src_valid[c]) begin
                sel_any = 1'b1;
                sel_idx = c[IW-1:0];
            end
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        rr_d      = rr_q;
        bcnt_d    = bcnt_q;
        trunc_d   = 1'b0;
        src_ready = '0;
        push      = 1'b0;
        push_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    gidx_d           = sel_idx;
                    bcnt_d           = '0;
                    state_d          = STREAM;
                end
            end
            STREAM: begin
                src_ready = grant_q & {N_SRC{skid_ready}};
                push      = g_valid & skid_ready;
                push_last = g_last | at_max;
                if (push) begin
                    bcnt_d = bcnt_q + 1'b1;
                    if (g_last) begin
                        rr_d    = next_rr(gidx_q);
                        grant_d = '0;
                        state_d = IDLE;
                    end else if (at_max) begin
                        trunc_d = 1'b1;
                        state_d = DISCARD;
                    end
                end
            end
            DISCARD: begin
                // Tail is swallowed at full rate, independent of the fabric.
                src_ready = grant_q;
                if (g_valid) begin
                    if (bcnt_q != {BCNT_W{1'b1}}) bcnt_d = bcnt_q + 1'b1;
                    if (g_last) begin
                        rr_d    = next_rr(gidx_q);
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wrf_clk or posedge wrf_rst) begin
        if (wrf_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= RR_BASE;
            bcnt_q  <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            bcnt_q  <= bcnt_d;
            trunc_q <= trunc_d;
        end
    end

    assign skid_in.last = push_last;
    assign skid_in.data = src_word[gidx_q];

    wrf_skid_buf #(.W(WRF_DW + 1)) u_skid (
        .wrf_clk   (wrf_clk),
        .wrf_rst   (wrf_rst),
        .in_valid  (push),
        .in_ready  (skid_ready),
        .in_data   (skid_in),
        .out_valid (wrf_valid),
        .out_ready (wrf_ready),
        .out_data  (skid_out)
    );

    assign wrf_last    = skid_out.last;
    assign wrf_data    = skid_out.data;
    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign frame_trunc = trunc_q;

endmodule

// File: tb/tb_wrf_tx_arbiter.sv
module tb_wrf_tx_arbiter;

    localparam int N    = 3;
    localparam int MAXB = 8;

    logic              wrf_clk = 1'b0;
    logic              wrf_rst;
    logic [N-1:0]      src_valid, src_last, src_ready, grant;
    logic [16*N-1:0]   src_data;
    logic              wrf_valid, wrf_last, wrf_ready, busy, frame_trunc;
    logic [15:0]       wrf_data;

    always #5 wrf_clk = ~wrf_clk;

    wrf_tx_arbiter #(.N_SRC(N), .MAX_BEATS(MAXB)) dut (
        .wrf_clk(wrf_clk), .wrf_rst(wrf_rst),
        .src_valid(src_valid), .src_last(src_last), .src_data(src_data),
        .src_ready(src_ready),
        .wrf_valid(wrf_valid), .wrf_last(wrf_last), .wrf_data(wrf_data),
        .wrf_ready(wrf_ready),
        .grant(grant), .busy(busy), .frame_trunc(frame_trunc)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- source drivers and reference model ----------------
    int           flen [N][$];    // frame lengths queued per source
    int           fi [N], bi [N]; // current frame / beat index per source
    int           rmode, scyc, occ, got_trunc, exp_trunc, mrr, last_pop, npop;
    bit           gap_en, chk_timing;
    logic [16:0]  expq [$];

    function automatic logic [15:0] beat_word(input int s, input int f, input int b);
        return {s[2:0], f[4:0], b[7:0]};
    endfunction

    function automatic bit drivers_done();
        for (int s = 0; s < N; s++) if (fi[s] < flen[s].size()) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        for (int s = 0; s < N; s++) begin
            if (fi[s] < flen[s].size()) begin
                src_data[s*16 +: 16] = beat_word(s, fi[s], bi[s]);
                src_last[s]  = (bi[s] == flen[s][fi[s]] - 1);
                src_valid[s] = (bi[s] == 0 || !gap_en) ? 1'b1 : ($urandom_range(3) != 0);
            end else begin
                src_data[s*16 +: 16] = 16'h0;
                src_last[s]  = 1'b0;
                src_valid[s] = 1'b0;
            end
        end
        case (rmode)
            0:       wrf_ready = 1'b1;
            1:       wrf_ready = ($urandom_range(9) < 7);
            default: wrf_ready = !(scyc >= 3 && scyc <= 7);
        endcase
    endtask

    // Frame-level model: sources with frames left always request at frame
    // start, so the service order is a plain rotation over those sources.
    task automatic build_expected();
        int nxt [N];
        int sel, L, n, base, c;
        for (int s = 0; s < N; s++) nxt[s] = 0;
        exp_trunc = 0;
        forever begin
            sel = -1;
`ifdef WRF_ARB_PRIO_EN
            if (nxt[0] < flen[0].size()) sel = 0;
            base = (mrr == 0) ? 1 : mrr;
            for (int k = 0; k < N - 1 && sel < 0; k++) begin
                c = 1 + ((base - 1 + k) % (N - 1));
                if (nxt[c] < flen[c].size()) sel = c;
            end
`else
            base = mrr;
            for (int k = 0; k < N && sel < 0; k++) begin
                c = (base + k) % N;
                if (nxt[c] < flen[c].size()) sel = c;
            end
`endif
            if (sel < 0) break;
            L = flen[sel][nxt[sel]];
            n = (L < MAXB) ? L : MAXB;
            for (int b = 0; b < n; b++) expq.push_back({(b == n - 1), beat_word(sel, nxt[sel], b)});
            if (L > MAXB) exp_trunc++;
            nxt[sel]++;
            mrr = (sel + 1) % N;
        end
    endtask

    // One clock: observe at negedge, then advance drivers after posedge.
    task automatic step();
        logic [N-1:0] dmask;
        logic [16:0]  e;
        int           push, pop;
        @(negedge wrf_clk);
        dmask = '0;
        for (int s = 0; s < N; s++)
            if (fi[s] < flen[s].size() && bi[s] >= MAXB) dmask[s] = 1'b1;
        chk("skid_occupancy_le2", 32'(occ <= 2), 1);
        chk("src_ready_onehot", 32'($countones(src_ready) <= 1), 1);
        if (occ == 2) chk("src_ready_when_full", 32'(src_ready & ~dmask), 0);
        if (frame_trunc) got_trunc++;
        push = 0; pop = 0;
        if (wrf_valid && wrf_ready) begin
            pop = 1;
            if (expq.size() == 0) begin
                chk("extra_output_beat", {15'h0, wrf_last, wrf_data}, 32'h1ffff);
            end else begin
                e = expq.pop_front();
                chk("out_beat", {15'h0, wrf_last, wrf_data}, {15'h0, e});
                if (chk_timing) begin
                    if (npop == 0)          chk("first_beat_latency", scyc, 2);
                    else if (e[7:0] == 0)   chk("interframe_bubble", scyc - last_pop, 2);
                    else                    chk("back_to_back", scyc - last_pop, 1);
                end
                last_pop = scyc;
                npop++;
            end
        end
        for (int s = 0; s < N; s++) begin
            if (src_valid[s] && src_ready[s]) begin
                if (bi[s] < MAXB) push++;
                if (bi[s] == flen[s][fi[s]] - 1) begin
                    bi[s] = 0;
                    fi[s]++;
                end else begin
                    bi[s]++;
                end
            end
        end
        occ = occ + push - pop;
        @(posedge wrf_clk);
        #1;
        scyc++;
        drive();
    endtask

    task automatic start_scn(input int rm, input bit gaps, input bit tim);
        rmode = rm; gap_en = gaps; chk_timing = tim;
        build_expected();
        scyc = 0; npop = 0; last_pop = 0; got_trunc = 0;
        @(posedge wrf_clk);
        #1;
        drive();
    endtask

    task automatic run_scn(input int rm, input bit gaps, input bit tim, input int budget);
        int cyc;
        start_scn(rm, gaps, tim);
        cyc = 0;
        while ((expq.size() != 0 || !drivers_done()) && cyc < budget) begin
            step();
            cyc++;
        end
        if (cyc >= budget) chk("scenario_timeout", 1, 0);
        repeat (4) step();
        chk("trunc_pulses", got_trunc, exp_trunc);
        chk("beats_missing", expq.size(), 0);
        chk("end_busy", busy, 0);
        chk("end_grant", grant, 0);
    endtask

    task automatic apply_reset();
        wrf_rst   = 1'b1;
        src_valid = '0; src_last = '0; src_data = '0; wrf_ready = 1'b0;
        repeat (2) @(posedge wrf_clk);
        @(negedge wrf_clk);
        wrf_rst = 1'b0;
        mrr = 0; occ = 0;
        expq.delete();
        for (int s = 0; s < N; s++) begin
            flen[s].delete();
            fi[s] = 0; bi[s] = 0;
        end
    endtask

    // ---------------- table-driven single-frame vectors ----------------
    typedef struct {
        logic        v, l;
        logic [15:0] d;
        logic        rdy;
        logic        ev, el;
        logic [15:0] ed;
        logic [2:0]  eg;
        logic        eb;
        logic [2:0]  esr;
    } vec_t;

    vec_t tv [9];

    initial begin
        int cyc;
        //        v  l  d      rdy ev el ed     eg  eb esr
        tv[0] = '{1, 0, 16'h1, 1,  0, 0, 16'h0, 0,  0, 0};
        tv[1] = '{1, 0, 16'h1, 1,  0, 0, 16'h0, 1,  1, 1};
        tv[2] = '{1, 0, 16'h2, 1,  1, 0, 16'h1, 1,  1, 1};
        tv[3] = '{1, 0, 16'h3, 1,  1, 0, 16'h2, 1,  1, 1};
        tv[4] = '{1, 0, 16'h4, 1,  1, 0, 16'h3, 1,  1, 1};
        tv[5] = '{1, 0, 16'h5, 1,  1, 0, 16'h4, 1,  1, 1};
        tv[6] = '{1, 1, 16'h6, 1,  1, 0, 16'h5, 1,  1, 1};
        tv[7] = '{0, 0, 16'h0, 1,  1, 1, 16'h6, 0,  0, 0};
        tv[8] = '{0, 0, 16'h0, 1,  0, 0, 16'h0, 0,  0, 0};

        // Reset values
        wrf_rst = 1'b1;
        src_valid = '0; src_last = '0; src_data = '0; wrf_ready = 1'b0;
        #3;
        chk("rst_wrf_valid", wrf_valid, 0);
        chk("rst_wrf_last", wrf_last, 0);
        chk("rst_wrf_data", wrf_data, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_trunc", frame_trunc, 0);
        apply_reset();

        // Single source, 6 beats, cycle-exact
        for (int t = 0; t < 9; t++) begin
            @(posedge wrf_clk);
            #1;
            src_valid = {2'b00, tv[t].v};
            src_last  = {2'b00, tv[t].l};
            src_data  = {32'h0, tv[t].d};
            wrf_ready = tv[t].rdy;
            @(negedge wrf_clk);
            chk($sformatf("vec%0d_wrf_valid", t), wrf_valid, tv[t].ev);
            if (tv[t].ev) begin
                chk($sformatf("vec%0d_wrf_data", t), wrf_data, tv[t].ed);
                chk($sformatf("vec%0d_wrf_last", t), wrf_last, tv[t].el);
            end
            chk($sformatf("vec%0d_grant", t), grant, tv[t].eg);
            chk($sformatf("vec%0d_busy", t), busy, tv[t].eb);
            chk($sformatf("vec%0d_src_ready", t), src_ready, tv[t].esr);
            chk($sformatf("vec%0d_frame_trunc", t), frame_trunc, 0);
        end

        // Round-robin with continuous requests, bubble timing checked
        apply_reset();
        for (int s = 0; s < N; s++) flen[s] = '{4, 4};
        run_scn(0, 0, 1, 500);

        // Back-pressure: fabric stalls for cycles 3..7 of an 8-beat frame
        apply_reset();
        flen[0] = '{8};
        run_scn(2, 0, 0, 500);

        // Truncation: 12-beat frame cut to MAX_BEATS, src2 frame follows
        apply_reset();
        flen[1] = '{12};
        flen[2] = '{3};
        run_scn(0, 0, 0, 500);

        // Asynchronous reset in the middle of a frame
        apply_reset();
        flen[0] = '{5};
        start_scn(0, 0, 0);
        cyc = 0;
        while (bi[0] < 2 && cyc < 50) begin
            step();
            cyc++;
        end
        if (cyc >= 50) chk("midrst_timeout", 1, 0);
        #2;
        wrf_rst = 1'b1;
        #1;
        chk("midrst_wrf_valid", wrf_valid, 0);
        chk("midrst_grant", grant, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_src_ready", src_ready, 0);
        apply_reset();
        flen[2] = '{3};
        run_scn(0, 0, 0, 500);

        // src0 and src2 competing (strict priority for src0 when enabled)
        apply_reset();
        flen[0] = '{3, 2, 4};
        flen[2] = '{2, 2};
        run_scn(1, 1, 0, 1000);

        // Randomized frames, gaps and fabric stalls
        for (int r = 0; r < 4; r++) begin
            apply_reset();
            for (int s = 0; s < N; s++) begin
                int nf;
                nf = $urandom_range(3);
                for (int f = 0; f < nf; f++) flen[s].push_back($urandom_range(1, 12));
            end
            run_scn(1, 1, 0, 3000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
